// File: rtl/alu_rhs_logic.sv
// Configurable 2-input logic unit for the ALU RHS path. Each bit works like a 74LS253 mux:
// the function code is selected by that bit's {RHS,LHS}. Optional Zero flag: ALU_RHS_ZFLAG_EN.
module alu_rhs_bit (
   input  logic [3:0] code,
   input  logic       lhs,
   input  logic       rhs,
   output logic       f
);
   assign f = code[{rhs, lhs}];
endmodule

module alu_rhs_logic #(
   parameter int WIDTH = 8
) (
   input  logic             AluClock,
   input  logic             AluReset,
   input  logic [WIDTH-1:0] LHS,
   input  logic [WIDTH-1:0] RHS,
   input  logic             AC0_RHS0,
   input  logic             AC1_RHS1,
   input  logic             AC2_RHS2,
   input  logic             AC3_RHS3,
`ifdef ALU_RHS_ZFLAG_EN
   output logic             Zero,
`endif
   output logic [WIDTH-1:0] Logic
);

   logic [3:0]       ac;
   logic [WIDTH-1:0] f;

   assign ac = {AC3_RHS3, AC2_RHS2, AC1_RHS1, AC0_RHS0};

   // Bits are independent, so there is no carry or cross-bit term.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      alu_rhs_bit u_bit (
         .code (ac),
         .lhs  (LHS[i]),
         .rhs  (RHS[i]),
         .f    (f[i])
      );
   end

   always_ff @(posedge AluClock) begin
      if (AluReset) Logic <= '0;
      else          Logic <= f;
   end

`ifdef ALU_RHS_ZFLAG_EN
   // Reset value of 1 agrees with Logic being cleared.
   always_ff @(posedge AluClock) begin
      if (AluReset) Zero <= 1'b1;
      else          Zero <= (f == '0);
   end
`endif

endmodule

// File: tb/tb_alu_rhs_logic.sv
// Scoreboard bench for alu_rhs_logic: stimulus pushes expectations, a monitor pops and
// compares one cycle later. Reference model is a sum-of-minterms truth table.
module tb_alu_rhs_logic;

   typedef struct {
      logic [7:0] val;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] lhs, rhs;
   logic [3:0] ac;
   logic [7:0] logic_o;
`ifdef ALU_RHS_ZFLAG_EN
   logic       zero_o;
`endif

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 0;

   always #5 clk = ~clk;

   alu_rhs_logic #(.WIDTH(8)) dut (
      .AluClock (clk),
      .AluReset (rst),
      .LHS      (lhs),
      .RHS      (rhs),
      .AC0_RHS0 (ac[0]),
      .AC1_RHS1 (ac[1]),
      .AC2_RHS2 (ac[2]),
      .AC3_RHS3 (ac[3]),
`ifdef ALU_RHS_ZFLAG_EN
      .Zero     (zero_o),
`endif
      .Logic    (logic_o)
   );

   // Each code bit is the output for one (RHS,LHS) minterm.
   function automatic logic [7:0] ref_f(logic [7:0] l, logic [7:0] r, logic [3:0] c);
      logic [7:0] res;
      res = 8'h00;
      if (c[0]) res = res | (~l & ~r);
      if (c[1]) res = res | ( l & ~r);
      if (c[2]) res = res | (~l &  r);
      if (c[3]) res = res | ( l &  r);
      return res;
   endfunction

   // Drive at negedge; optional glitch puts the inverted code on AC briefly before the edge.
   task automatic step(input logic [7:0] l, input logic [7:0] r, input logic [3:0] c,
                       input logic rs, input logic [7:0] expv, input string nm,
                       input bit glitch = 0);
      exp_t e;
      @(negedge clk);
      lhs = l; rhs = r; rst = rs;
      if (glitch) begin
         ac = ~c;
         #2;
      end
      ac = c;
      e.val = expv; e.name = nm;
      q.push_back(e);
   endtask

   // Monitor: output is presented every cycle, checked #1 after the capturing edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (logic_o !== e.val) begin
               errors++;
               $display("FAIL %s: Logic got %h expected %h", e.name, logic_o, e.val);
            end
`ifdef ALU_RHS_ZFLAG_EN
            checks++;
            if (zero_o !== (e.val == 8'h00)) begin
               errors++;
               $display("FAIL %s zero: Zero got %b expected %b", e.name, zero_o, (e.val == 8'h00));
            end
`endif
         end
      end
   end

   initial begin
      logic [7:0] l, r;
      logic [3:0] c;
      logic       rs;
      int         wait_cyc;
      lhs = 8'h00; rhs = 8'h00; ac = 4'h0; rst = 1'b1;

      // Reset and release
      step(8'hCC, 8'hF0, 4'hF, 1'b1, 8'h00, "reset");
      step(8'hCC, 8'hF0, 4'hF, 1'b0, 8'hFF, "post_reset");

      // Directed codes
      step(8'hCC, 8'hF0, 4'hC, 1'b0, 8'hF0, "code_C");
      step(8'hCC, 8'hF0, 4'h3, 1'b0, 8'h0F, "code_3");
      step(8'hCC, 8'hF0, 4'h0, 1'b0, 8'h00, "code_0");
      step(8'hCC, 8'hF0, 4'hF, 1'b0, 8'hFF, "code_F");
      step(8'hCC, 8'hF0, 4'h8, 1'b0, 8'hC0, "code_8");
      step(8'hCC, 8'hF0, 4'hE, 1'b0, 8'hFC, "code_E");
      step(8'hCC, 8'hF0, 4'h6, 1'b0, 8'h3C, "code_6");
      step(8'hCC, 8'hF0, 4'hA, 1'b0, 8'hCC, "code_A");
      step(8'hCC, 8'hF0, 4'h5, 1'b0, 8'h33, "code_5");
      step(8'hCC, 8'hF0, 4'h1, 1'b0, 8'h03, "code_1");
      step(8'hCC, 8'hF0, 4'h7, 1'b0, 8'h3F, "code_7");
      step(8'hCC, 8'hF0, 4'h9, 1'b0, 8'hC3, "code_9");

      // Sweep all codes against the model
      for (int i = 0; i < 16; i++) begin
         c = 4'(i);
         step(8'hCC, 8'hF0, c, 1'b0, ref_f(8'hCC, 8'hF0, c), "sweep");
      end

      // Mid-cycle glitch on AC must not reach Logic
      step(8'hCC, 8'hF0, 4'h6, 1'b0, 8'h3C, "glitch_6", 1);
      step(8'hCC, 8'hF0, 4'h8, 1'b0, 8'hC0, "glitch_8", 1);

      // Reset mid-stream, then resume
      step(8'h5A, 8'h0F, 4'h6, 1'b0, 8'h55, "stream_a");
      step(8'h5A, 8'h0F, 4'h6, 1'b1, 8'h00, "stream_rst");
      step(8'h5A, 8'h0F, 4'h6, 1'b0, 8'h55, "stream_resume");

      // Random traffic with occasional reset
      for (int i = 0; i < 300; i++) begin
         l  = 8'($urandom);
         r  = 8'($urandom);
         c  = 4'($urandom);
         rs = ($urandom_range(0, 19) == 0);
         step(l, r, c, rs, rs ? 8'h00 : ref_f(l, r, c), "random", ($urandom_range(0, 3) == 0));
      end

      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
